z3_slave_engine: RTL and testbench



---
 rtl/z3_slave_engine_pkg.sv | 19 +
 rtl/z3_slave_engine_if.sv | 29 ++
 rtl/z3_addr_decode.sv | 28 ++
 rtl/z3_slave_engine.sv | 124 ++++++++++++
 tb/tb_z3_slave_engine.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/z3_slave_engine_pkg.sv
// rtl/z3_slave_engine_pkg.sv - shared state encodings and helpers for the Zorro III slave engine
package z3_slave_engine_pkg;

    typedef enum logic [2:0] {
        Z3_IDLE  = 3'd0,
        Z3_START = 3'd1,
        Z3_DATA  = 3'd2,
        Z3_END   = 3'd3,
        Z3_ERR   = 3'd4
    } z3_state_t;

    localparam logic [3:0] DS_NONE = 4'b1111;

    // Any strobe low counts; the whole nibble is compared, not a single bit.
    function automatic logic ds_active(input logic [3:0] ds_n);
        return ds_n != DS_NONE;
    endfunction

endpackage

// File: rtl/z3_slave_engine_if.sv
// rtl/z3_slave_engine_if.sv - Zorro III slave bus and target-select bundle
interface z3_slave_engine_if #(
    parameter int N_TGT  = 4,
    parameter int ADDR_W = 7
);
    logic                      FCS_n;
    logic                      READ;
    logic [3:0]                DS_n;
    logic                      match;
    logic                      validspace;
    logic [ADDR_W-1:0]         ADDR;
    logic [N_TGT*ADDR_W-1:0]   TGT_BASE;
    logic [N_TGT*ADDR_W-1:0]   TGT_MASK;
    logic [N_TGT-1:0]          tgt_ack;
    logic [N_TGT-1:0]          tgt_sel;
    logic                      DTACK;
    logic                      BERR;
    logic                      busy;

    modport master (
        output FCS_n, READ, DS_n, match, validspace, ADDR, TGT_BASE, TGT_MASK, tgt_ack,
        input  tgt_sel, DTACK, BERR, busy
    );

    modport slave (
        input  FCS_n, READ, DS_n, match, validspace, ADDR, TGT_BASE, TGT_MASK, tgt_ack,
        output tgt_sel, DTACK, BERR, busy
    );
endinterface

// File: rtl/z3_addr_decode.sv
// rtl/z3_addr_decode.sv - base/mask window compare with lowest-index priority select
module z3_addr_decode
    import z3_slave_engine_pkg::*;
#(
    parameter int N_TGT  = 4,
    parameter int ADDR_W = 7
) (
    input  logic [ADDR_W-1:0]       i_addr,
    input  logic [N_TGT*ADDR_W-1:0] i_base,
    input  logic [N_TGT*ADDR_W-1:0] i_mask,
    output logic [N_TGT-1:0]        o_sel,
    output logic                    o_hit
);

    // Walk from the top index down so the lowest hitting target is written last.
    always_comb begin
        o_sel = '0;
        o_hit = 1'b0;
        for (int i = N_TGT - 1; i >= 0; i--) begin
            if (((i_addr ^ i_base[i*ADDR_W +: ADDR_W]) & i_mask[i*ADDR_W +: ADDR_W]) == '0) begin
                o_sel    = '0;
                o_sel[i] = 1'b1;
                o_hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/z3_slave_engine.sv
// rtl/z3_slave_engine.sv - Zorro III slave cycle engine; watchdog and ERR state under Z3_SLAVE_TIMEOUT_EN
module z3_slave_engine
    import z3_slave_engine_pkg::*;
#(
    parameter int N_TGT       = 4,
    parameter int ADDR_W      = 7,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             CLK,
    input  logic             RST,
    z3_slave_engine_if.slave bus
);

    z3_state_t          r_state, w_next;
    logic [N_TGT-1:0]   r_sel, w_sel_next;
    logic [N_TGT-1:0]   r_tgt_sel;
    logic               r_dtack;
    logic               r_busy;
    logic [N_TGT-1:0]   w_hit_vec;
    logic               w_hit;
    logic               w_cyc_req;
    logic               w_ack;
    logic               w_timeout;

    assign w_cyc_req = !bus.FCS_n && bus.match && bus.validspace;
    assign w_ack     = |(bus.tgt_ack & r_sel);

    z3_addr_decode #(
        .N_TGT  (N_TGT),
        .ADDR_W (ADDR_W)
    ) u_decode (
        .i_addr (bus.ADDR),
        .i_base (bus.TGT_BASE),
        .i_mask (bus.TGT_MASK),
        .o_sel  (w_hit_vec),
        .o_hit  (w_hit)
    );

`ifdef Z3_SLAVE_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_berr;

    assign w_timeout = (r_cnt == CNT_LAST);

    // Saturating so a held DATA state can never wrap back below the terminal count.
    always_ff @(posedge CLK) begin
        if (RST || r_state != Z3_DATA)
            r_cnt <= '0;
        else if (r_cnt != CNT_LAST)
            r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) r_berr <= 1'b0;
        else     r_berr <= (w_next == Z3_ERR);
    end

    assign bus.BERR = r_berr;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYC > 0);
    assign w_timeout    = 1'b0;
    assign bus.BERR     = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_sel_next = r_sel;
        case (r_state)
            Z3_IDLE: begin
                w_sel_next = '0;
                if (w_cyc_req) begin
                    w_next     = Z3_START;
                    w_sel_next = w_hit ? w_hit_vec : '0;
                end
            end
            Z3_START: begin
                if (bus.FCS_n)                          w_next = Z3_IDLE;
                else if (bus.READ || ds_active(bus.DS_n)) w_next = Z3_DATA;
            end
            Z3_DATA: begin
                if (bus.FCS_n)      w_next = Z3_IDLE;
                else if (w_ack)     w_next = Z3_END;
`ifdef Z3_SLAVE_TIMEOUT_EN
                else if (w_timeout) w_next = Z3_ERR;
`endif
            end
            Z3_END: begin
                if (bus.FCS_n) w_next = Z3_IDLE;
            end
`ifdef Z3_SLAVE_TIMEOUT_EN
            Z3_ERR: begin
                if (bus.FCS_n) w_next = Z3_IDLE;
            end
`endif
            default: w_next = Z3_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= Z3_IDLE;
            r_sel     <= '0;
            r_tgt_sel <= '0;
            r_dtack   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_sel     <= w_sel_next;
            r_tgt_sel <= (w_next == Z3_START || w_next == Z3_DATA || w_next == Z3_END) ? w_sel_next : '0;
            r_dtack   <= (w_next == Z3_END);
            r_busy    <= (w_next != Z3_IDLE);
        end
    end

    assign bus.tgt_sel = r_tgt_sel;
    assign bus.DTACK   = r_dtack;
    assign bus.busy    = r_busy;

endmodule

// File: tb/tb_z3_slave_engine.sv
// tb/tb_z3_slave_engine.sv - directed self-checking bench for z3_slave_engine
module tb_z3_slave_engine;

    logic       clk;
    logic       rst;
    int         total;
    int         bad;
    logic [6:0] obs;

    z3_slave_engine_if #(.N_TGT(4), .ADDR_W(7)) bus ();

    z3_slave_engine #(
        .N_TGT       (4),
        .ADDR_W      (7),
        .TIMEOUT_CYC (8)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // obs packs {tgt_sel[3:0], DTACK, BERR, busy}
    task automatic tick();
        @(posedge clk);
        #1;
        obs = {bus.tgt_sel, bus.DTACK, bus.BERR, bus.busy};
    endtask

    task automatic bus_idle();
        bus.FCS_n      = 1'b1;
        bus.READ       = 1'b0;
        bus.DS_n       = 4'b1111;
        bus.match      = 1'b1;
        bus.validspace = 1'b1;
        bus.tgt_ack    = 4'b0000;
    endtask

    task automatic cfg_single();
        bus.TGT_BASE = {7'h03, 7'h10, 7'h02, 7'h01};
        bus.TGT_MASK = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
    endtask

    task automatic open_cycle(input logic [6:0] addr, input logic rd, input logic [3:0] ds);
        bus.ADDR  = addr;
        bus.READ  = rd;
        bus.DS_n  = ds;
        bus.FCS_n = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_idle();
        cfg_single();
        bus.ADDR = 7'h00;
        tick();
        tick();
        total++;
        if (obs !== 7'b0000_000) begin bad++; $display("FAIL reset_state got=%b exp=%b", obs, 7'b0000_000); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_idle_gate();
        bus.validspace = 1'b0;
        open_cycle(7'h10, 1'b1, 4'b1111);
        tick();
        total++;
        if (obs !== 7'b0000_000) begin bad++; $display("FAIL gate_validspace got=%b exp=%b", obs, 7'b0000_000); end
        bus.validspace = 1'b1;
        bus.match      = 1'b0;
        tick();
        total++;
        if (obs !== 7'b0000_000) begin bad++; $display("FAIL gate_match got=%b exp=%b", obs, 7'b0000_000); end
        bus_idle();
        tick();
    endtask

    task automatic test_read_ack();
        open_cycle(7'h10, 1'b1, 4'b1111);
        total++;
        if (obs !== 7'b0100_001) begin bad++; $display("FAIL read_start got=%b exp=%b", obs, 7'b0100_001); end
        tick();
        tick();
        total++;
        if (obs !== 7'b0100_001) begin bad++; $display("FAIL read_data got=%b exp=%b", obs, 7'b0100_001); end
        bus.tgt_ack = 4'b0100;
        tick();
        total++;
        if (obs !== 7'b0100_101) begin bad++; $display("FAIL read_dtack got=%b exp=%b", obs, 7'b0100_101); end
        bus.tgt_ack = 4'b0000;
        tick();
        total++;
        if (obs !== 7'b0100_101) begin bad++; $display("FAIL read_hold got=%b exp=%b", obs, 7'b0100_101); end
        bus.FCS_n = 1'b1;
        tick();
        total++;
        if (obs !== 7'b0000_000) begin bad++; $display("FAIL read_release got=%b exp=%b", obs, 7'b0000_000); end
        bus_idle();
    endtask

    task automatic test_min_latency();
        open_cycle(7'h10, 1'b1, 4'b1111);
        bus.tgt_ack = 4'b0100;
        tick();
        total++;
        if (obs !== 7'b0100_001) begin bad++; $display("FAIL min_lat_data got=%b exp=%b", obs, 7'b0100_001); end
        tick();
        total++;
        if (obs !== 7'b0100_101) begin bad++; $display("FAIL min_lat_dtack got=%b exp=%b", obs, 7'b0100_101); end
        bus_idle();
        tick();
    endtask

    task automatic test_priority();
        bus.TGT_BASE = {7'h00, 7'h00, 7'h7F, 7'h7F};
        bus.TGT_MASK = {7'h00, 7'h7F, 7'h00, 7'h7F};
        open_cycle(7'h10, 1'b1, 4'b1111);
        total++;
        if (obs !== 7'b0010_001) begin bad++; $display("FAIL prio_sel got=%b exp=%b", obs, 7'b0010_001); end
        bus.tgt_ack = 4'b1000;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (obs !== 7'b0010_001) begin bad++; $display("FAIL prio_wrong_ack got=%b exp=%b", obs, 7'b0010_001); end
        bus.tgt_ack = 4'b0010;
        tick();
        total++;
        if (obs !== 7'b0010_101) begin bad++; $display("FAIL prio_right_ack got=%b exp=%b", obs, 7'b0010_101); end
        bus_idle();
        tick();
        cfg_single();
    endtask

    task automatic test_no_hit();
        open_cycle(7'h55, 1'b1, 4'b1111);
        total++;
        if (obs !== 7'b0000_001) begin bad++; $display("FAIL nohit_start got=%b exp=%b", obs, 7'b0000_001); end
        bus.tgt_ack = 4'b1111;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (obs !== 7'b0000_001) begin bad++; $display("FAIL nohit_no_dtack got=%b exp=%b", obs, 7'b0000_001); end
        bus_idle();
        tick();
        total++;
        if (obs !== 7'b0000_000) begin bad++; $display("FAIL nohit_release got=%b exp=%b", obs, 7'b0000_000); end
    endtask

    task automatic test_write_ds();
        open_cycle(7'h10, 1'b0, 4'b1111);
        bus.tgt_ack = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (obs !== 7'b0100_001) begin bad++; $display("FAIL write_start_hold%0d got=%b exp=%b", i, obs, 7'b0100_001); end
        end
        bus.DS_n = 4'b1110;
        tick();
        total++;
        if (obs !== 7'b0100_001) begin bad++; $display("FAIL write_data got=%b exp=%b", obs, 7'b0100_001); end
        tick();
        total++;
        if (obs !== 7'b0100_101) begin bad++; $display("FAIL write_dtack got=%b exp=%b", obs, 7'b0100_101); end
        bus_idle();
        tick();
        open_cycle(7'h10, 1'b0, 4'b0111);
        bus.tgt_ack = 4'b0100;
        tick();
        tick();
        total++;
        if (obs !== 7'b0100_101) begin bad++; $display("FAIL write_ds_upper got=%b exp=%b", obs, 7'b0100_101); end
        bus_idle();
        tick();
    endtask

    task automatic test_timeout();
        open_cycle(7'h10, 1'b1, 4'b1111);
        tick();
`ifdef Z3_SLAVE_TIMEOUT_EN
        for (int i = 1; i < 8; i++) tick();
        total++;
        if (obs !== 7'b0100_001) begin bad++; $display("FAIL timeout_before got=%b exp=%b", obs, 7'b0100_001); end
        tick();
        total++;
        if (obs !== 7'b0000_011) begin bad++; $display("FAIL timeout_berr got=%b exp=%b", obs, 7'b0000_011); end
        bus.tgt_ack = 4'b0100;
        tick();
        tick();
        total++;
        if (obs !== 7'b0000_011) begin bad++; $display("FAIL timeout_hold got=%b exp=%b", obs, 7'b0000_011); end
`else
        for (int i = 0; i < 12; i++) tick();
        total++;
        if (obs !== 7'b0100_001) begin bad++; $display("FAIL notimeout_data got=%b exp=%b", obs, 7'b0100_001); end
        bus.tgt_ack = 4'b0100;
        tick();
        total++;
        if (obs !== 7'b0100_101) begin bad++; $display("FAIL notimeout_late_ack got=%b exp=%b", obs, 7'b0100_101); end
`endif
        bus.FCS_n = 1'b1;
        tick();
        total++;
        if (obs !== 7'b0000_000) begin bad++; $display("FAIL timeout_release got=%b exp=%b", obs, 7'b0000_000); end
        bus_idle();
    endtask

    task automatic test_ack_release_same();
        open_cycle(7'h10, 1'b1, 4'b1111);
        tick();
        bus.tgt_ack = 4'b0100;
        bus.FCS_n   = 1'b1;
        tick();
        total++;
        if (obs !== 7'b0000_000) begin bad++; $display("FAIL ack_vs_release got=%b exp=%b", obs, 7'b0000_000); end
        bus.tgt_ack = 4'b0000;
        tick();
        total++;
        if (obs !== 7'b0000_000) begin bad++; $display("FAIL ack_vs_release_after got=%b exp=%b", obs, 7'b0000_000); end
    endtask

    task automatic test_ack_terminal();
        open_cycle(7'h10, 1'b1, 4'b1111);
        tick();
        for (int i = 1; i < 8; i++) tick();
        bus.tgt_ack = 4'b0100;
        tick();
        total++;
        if (obs !== 7'b0100_101) begin bad++; $display("FAIL ack_at_terminal got=%b exp=%b", obs, 7'b0100_101); end
        tick();
        total++;
        if (obs !== 7'b0100_101) begin bad++; $display("FAIL ack_terminal_hold got=%b exp=%b", obs, 7'b0100_101); end
        bus_idle();
        tick();
    endtask

    task automatic test_reset_mid();
        open_cycle(7'h10, 1'b1, 4'b1111);
        bus.tgt_ack = 4'b0100;
        tick();
        tick();
        total++;
        if (obs !== 7'b0100_101) begin bad++; $display("FAIL rstmid_end got=%b exp=%b", obs, 7'b0100_101); end
        rst = 1'b1;
        tick();
        total++;
        if (obs !== 7'b0000_000) begin bad++; $display("FAIL rstmid_clear got=%b exp=%b", obs, 7'b0000_000); end
        rst = 1'b0;
        bus_idle();
        tick();
        open_cycle(7'h10, 1'b1, 4'b1111);
        total++;
        if (obs !== 7'b0100_001) begin bad++; $display("FAIL rstmid_restart got=%b exp=%b", obs, 7'b0100_001); end
        tick();
        bus.tgt_ack = 4'b0100;
        tick();
        total++;
        if (obs !== 7'b0100_101) begin bad++; $display("FAIL rstmid_fresh_dtack got=%b exp=%b", obs, 7'b0100_101); end
        bus_idle();
        tick();
        total++;
        if (obs !== 7'b0000_000) begin bad++; $display("FAIL rstmid_final got=%b exp=%b", obs, 7'b0000_000); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        obs   = '0;
        rst   = 1'b1;
        bus.ADDR     = 7'h00;
        bus.TGT_BASE = '0;
        bus.TGT_MASK = '0;
        bus_idle();
        test_reset();
        test_idle_gate();
        test_read_ack();
        test_min_latency();
        test_priority();
        test_no_hit();
        test_write_ds();
        test_timeout();
        test_ack_release_same();
        test_ack_terminal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
